// File: rtl/mux_sweep_capture_if.sv
// Bundle of stimulus/capture signals between the sweep engine and its user.
// The master side issues start and returns the mux output y_in; the slave
// side (the sweep engine) drives the mux inputs and reports status/results.
// Optional checker signals exist only when MUX_SWEEP_CHECK_EN is defined.
interface mux_sweep_capture_if;
  logic        start;
  logic        y_in;
  logic        a;
  logic        b;
  logic        c;
  logic        d;
  logic [3:0]  vec_idx;
  logic        busy;
  logic        done;
  logic [15:0] truth_table;
`ifdef MUX_SWEEP_CHECK_EN
  logic        mismatch;
  logic [15:0] err_mask;

  modport master (
    output start, y_in,
    input  a, b, c, d, vec_idx, busy, done, truth_table, mismatch, err_mask
  );

  modport slave (
    input  start, y_in,
    output a, b, c, d, vec_idx, busy, done, truth_table, mismatch, err_mask
  );
`else
  modport master (
    output start, y_in,
    input  a, b, c, d, vec_idx, busy, done, truth_table
  );

  modport slave (
    input  start, y_in,
    output a, b, c, d, vec_idx, busy, done, truth_table
  );
`endif
endinterface

// File: rtl/mux_sweep_capture.sv
// Self-sequencing stimulus/capture stage for a 4-input combinational mux.
// On start it walks {a,b,c,d} through 0..15, holds each vector for
// SETTLE_CYCLES cycles, samples y_in and packs the result into truth_table.
// Optional compile-time feature: MUX_SWEEP_CHECK_EN adds err_mask/mismatch,
// comparing the finished table against EXP_TABLE.
module mux_sweep_capture #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [15:0] EXP_TABLE     = 16'hFF00
) (
  input logic                clk,
  input logic                rst,
  mux_sweep_capture_if.slave sw
);

  // A settle time of 0 is treated as 1 so SETTLE always lasts at least a cycle.
  localparam int unsigned SETTLE_EFF = (SETTLE_CYCLES == 0) ? 1 : SETTLE_CYCLES;
  localparam logic [7:0]  CNT_LAST   = 8'(SETTLE_EFF - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  state_t      state_reg, state_next;
  logic [3:0]  vec_reg, vec_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic [15:0] tt_reg, tt_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic [15:0] tt_sampled;

`ifdef MUX_SWEEP_CHECK_EN
  logic [15:0] err_reg, err_next;
  logic        mis_reg, mis_next;
`else
  logic unused_exp_table;
  assign unused_exp_table = ^EXP_TABLE;
`endif

  // Table as it will look after the current vector's bit is captured.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_sample
      assign tt_sampled[gi] = (vec_reg == 4'(gi)) ? sw.y_in : tt_reg[gi];
    end
  endgenerate

  // State and datapath registers; rst abandons any sweep in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      vec_reg   <= 4'd0;
      cnt_reg   <= 8'd0;
      tt_reg    <= 16'h0000;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
`ifdef MUX_SWEEP_CHECK_EN
      err_reg   <= 16'h0000;
      mis_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      vec_reg   <= vec_next;
      cnt_reg   <= cnt_next;
      tt_reg    <= tt_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
`ifdef MUX_SWEEP_CHECK_EN
      err_reg   <= err_next;
      mis_reg   <= mis_next;
`endif
    end
  end

  // Next-state and datapath updates; everything holds unless a state acts.
  always_comb begin
    state_next = state_reg;
    vec_next   = vec_reg;
    cnt_next   = cnt_reg;
    tt_next    = tt_reg;
    busy_next  = busy_reg;
    done_next  = done_reg;
`ifdef MUX_SWEEP_CHECK_EN
    err_next   = err_reg;
    mis_next   = mis_reg;
`endif
    case (state_reg)
      IDLE, DONE: begin
        // start is only honoured here, so it is ignored while busy.
        if (sw.start) begin
          vec_next   = 4'd0;
          cnt_next   = 8'd0;
          tt_next    = 16'h0000;
          busy_next  = 1'b1;
          done_next  = 1'b0;
          state_next = SETTLE;
`ifdef MUX_SWEEP_CHECK_EN
          err_next   = 16'h0000;
          mis_next   = 1'b0;
`endif
        end
      end
      SETTLE: begin
        cnt_next = cnt_reg + 8'd1;
        if (cnt_reg == CNT_LAST) begin
          state_next = SAMPLE;
        end
      end
      SAMPLE: begin
        tt_next = tt_sampled;
        if (vec_reg == 4'hF) begin
          // Last vector: stop here, the index never wraps.
          busy_next  = 1'b0;
          done_next  = 1'b1;
          state_next = DONE;
`ifdef MUX_SWEEP_CHECK_EN
          err_next   = tt_sampled ^ EXP_TABLE;
          mis_next   = |(tt_sampled ^ EXP_TABLE);
`endif
        end else begin
          vec_next   = vec_reg + 4'd1;
          cnt_next   = 8'd0;
          state_next = SETTLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign sw.a           = vec_reg[3];
  assign sw.b           = vec_reg[2];
  assign sw.c           = vec_reg[1];
  assign sw.d           = vec_reg[0];
  assign sw.vec_idx     = vec_reg;
  assign sw.busy        = busy_reg;
  assign sw.done        = done_reg;
  assign sw.truth_table = tt_reg;
`ifdef MUX_SWEEP_CHECK_EN
  assign sw.err_mask    = err_reg;
  assign sw.mismatch    = mis_reg;
`endif

endmodule

// File: tb/tb_mux_sweep_capture.sv
// Bench for mux_sweep_capture: two instances (settle 1 and settle 3) share
// start/rst; each has its own modelled mux on y_in. Expected traces are
// derived from the sweep timing rules, tables from a behavioural mux model.
module tb_mux_sweep_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  int          mode;
  logic [15:0] rand_tbl;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  // Modelled mux output for vector v = {a,b,c,d} under each stimulus mode.
  function automatic logic y_fn(input int m, input logic [15:0] rt, input logic [3:0] v);
    logic av, bv, cv, dv;
    av = v[3]; bv = v[2]; cv = v[1]; dv = v[0];
    case (m)
      0: return av;
      1: return dv;
      2: begin
        // 4:1 mux, select {a,b}, data inputs c, d, c^d, c|d
        case ({av, bv})
          2'd0:    return cv;
          2'd1:    return dv;
          2'd2:    return cv ^ dv;
          default: return cv | dv;
        endcase
      end
      3: return rt[v];
      4: return (v == 4'd3) ? 1'b1 : av;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] model_table(input int m, input logic [15:0] rt);
    logic [15:0] t;
    for (int i = 0; i < 16; i++) t[i] = y_fn(m, rt, 4'(i));
    return t;
  endfunction

  mux_sweep_capture_if if1 ();
  mux_sweep_capture_if if3 ();

  assign if1.start = start;
  assign if3.start = start;
  assign if1.y_in  = y_fn(mode, rand_tbl, {if1.a, if1.b, if1.c, if1.d});
  assign if3.y_in  = y_fn(mode, rand_tbl, {if3.a, if3.b, if3.c, if3.d});

  mux_sweep_capture #(.SETTLE_CYCLES(1), .EXP_TABLE(16'hFF00)) dut1 (
    .clk(clk), .rst(rst), .sw(if1)
  );
  mux_sweep_capture #(.SETTLE_CYCLES(3), .EXP_TABLE(16'hFF00)) dut3 (
    .clk(clk), .rst(rst), .sw(if3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Compare one cycle of a DUT against the timing rules; k = edges since start.
  task automatic trace_chk(input int s, input int k, input logic [15:0] full,
                           input logic [3:0] vi, input logic [3:0] abcd,
                           input logic bsy, input logic dn, input logic [15:0] tt,
                           input logic [15:0] em, input logic mis,
                           inout int bad, inout string first);
    int          per, evec;
    logic        ebusy;
    logic [15:0] ett, eerr;
    per   = s + 1;
    evec  = k / per;
    if (evec > 15) evec = 15;
    ebusy = (k < 16 * per);
    ett   = 16'h0;
    for (int v = 0; v < 16; v++) if ((v + 1) * per <= k) ett[v] = full[v];
    eerr  = ebusy ? 16'h0 : (full ^ 16'hFF00);
    if (vi !== 4'(evec) || abcd !== 4'(evec) || bsy !== ebusy || dn !== !ebusy || tt !== ett
`ifdef MUX_SWEEP_CHECK_EN
        || em !== eerr || mis !== (|eerr)
`endif
       ) begin
      if (bad == 0)
        first = $sformatf("k=%0d vec=%0h/%0h abcd=%0h busy=%b/%b done=%b tt=%h/%h",
                          k, vi, evec, abcd, bsy, ebusy, dn, tt, ett);
      bad++;
    end
    if (em === 16'hxxxx) bad++;  // keeps em/mis referenced in every build
  endtask

  // One sweep on both DUTs; optional start re-pulse or reset at edge k.
  task automatic run_sweep(input string tag, input int restart_at, input int rst_at);
    logic [15:0] full;
    logic [15:0] em1, em3;
    logic        mis1, mis3;
    int          bad1, bad3, rise1, rise3;
    string       first1, first3;
    full = model_table(mode, rand_tbl);
    bad1 = 0; bad3 = 0; rise1 = -1; rise3 = -1;
    first1 = ""; first3 = "";
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_k0_s1"}, {29'd0, if1.busy, if1.done, |if1.truth_table}, {29'd0, 3'b100});
    for (int k = 0; k <= 68; k++) begin
      if (k == rst_at) begin
        check({tag, "_rst_s1"}, {if1.vec_idx, 3'd0, if1.busy, if1.done, if1.truth_table}, 0);
        check({tag, "_rst_s3"}, {if3.vec_idx, 3'd0, if3.busy, if3.done, if3.truth_table}, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check({tag, "_idle_after_rst"}, {if1.vec_idx, if3.vec_idx, if1.busy, if3.busy}, 0);
        return;
      end
`ifdef MUX_SWEEP_CHECK_EN
      em1 = if1.err_mask; mis1 = if1.mismatch; em3 = if3.err_mask; mis3 = if3.mismatch;
`else
      em1 = 16'h0; mis1 = 1'b0; em3 = 16'h0; mis3 = 1'b0;
`endif
      trace_chk(1, k, full, if1.vec_idx, {if1.a, if1.b, if1.c, if1.d}, if1.busy, if1.done,
                if1.truth_table, em1, mis1, bad1, first1);
      trace_chk(3, k, full, if3.vec_idx, {if3.a, if3.b, if3.c, if3.d}, if3.busy, if3.done,
                if3.truth_table, em3, mis3, bad3, first3);
      if (rise1 < 0 && if1.done) rise1 = k;
      if (rise3 < 0 && if3.done) rise3 = k;
      start = (k + 1 == restart_at);
      if (k + 1 == rst_at) rst = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
    if (bad1 != 0) $display("trace detail s1: %s", first1);
    if (bad3 != 0) $display("trace detail s3: %s", first3);
    check({tag, "_trace_s1"}, 32'(bad1), 0);
    check({tag, "_trace_s3"}, 32'(bad3), 0);
    check({tag, "_done_edge_s1"}, 32'(rise1), 32);
    check({tag, "_done_edge_s3"}, 32'(rise3), 64);
  endtask

  typedef struct {
    string       name;
    int          m;
    int          restart_at;
    logic [15:0] exp_tt;
    logic [15:0] exp_err;
  } vec_t;

  vec_t vecs [5];

  initial begin
    vecs[0] = '{"y_eq_a",       0, -1, 16'hFF00, 16'h0000};
    vecs[1] = '{"y_eq_d",       1, -1, 16'hAAAA, 16'h55AA};
    vecs[2] = '{"real_mux",     2, -1, 16'hE6AC, 16'h19AC};
    vecs[3] = '{"a_bad_vec3",   4, -1, 16'hFF08, 16'h0008};
    vecs[4] = '{"start_ignored",0, 10, 16'hFF00, 16'h0000};

    rst = 1'b1; start = 1'b0; mode = 0; rand_tbl = 16'h0;
    repeat (3) @(negedge clk);
    check("reset_s1", {if1.vec_idx, if1.a, if1.b, if1.c, if1.d, if1.busy, if1.done, if1.truth_table}, 0);
    check("reset_s3", {if3.vec_idx, if3.a, if3.b, if3.c, if3.d, if3.busy, if3.done, if3.truth_table}, 0);
`ifdef MUX_SWEEP_CHECK_EN
    check("reset_chk", {if1.mismatch, if1.err_mask}, 0);
`endif
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      mode = vecs[i].m;
      run_sweep(vecs[i].name, vecs[i].restart_at, -1);
      check({vecs[i].name, "_tt_s1"}, 32'(if1.truth_table), 32'(vecs[i].exp_tt));
      check({vecs[i].name, "_tt_s3"}, 32'(if3.truth_table), 32'(vecs[i].exp_tt));
`ifdef MUX_SWEEP_CHECK_EN
      check({vecs[i].name, "_err"}, {15'd0, if1.mismatch, if1.err_mask},
            {15'd0, |vecs[i].exp_err, vecs[i].exp_err});
`endif
    end

    // Reset in the middle of a sweep, then a clean full sweep.
    mode = 2;
    run_sweep("mid_rst", -1, 15);
    run_sweep("after_rst", -1, -1);
    check("after_rst_tt_s1", 32'(if1.truth_table), 32'h0000E6AC);

    // Random truth tables against the model.
    for (int r = 0; r < 4; r++) begin
      mode = 3;
      rand_tbl = 16'($urandom);
      run_sweep($sformatf("rand%0d", r), -1, -1);
      check($sformatf("rand%0d_tt_s1", r), 32'(if1.truth_table), 32'(model_table(3, rand_tbl)));
      check($sformatf("rand%0d_tt_s3", r), 32'(if3.truth_table), 32'(model_table(3, rand_tbl)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
